// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the streaming pooling unit:
//   POOL_AVG / POOL_MAX  - run-time pooling mode encodings
//   log2_int             - ceiling log2 for elaboration-time sizing
//   calc_acc_width       - accumulator width that can hold a full window sum
//   calc_ifm_size_next   - output map edge after floor division by the kernel
//   counter_width        - bits needed to hold values 0..max_value
// ---------------------------------------------------------------------------
package pool_pkg;

  localparam logic POOL_AVG = 1'b0;
  localparam logic POOL_MAX = 1'b1;

  function automatic int log2_int(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // A KxK window sum grows by log2(K*K) bits over a single pixel.
  function automatic int calc_acc_width(input int data_width, input int kernel);
    return data_width + 2 * log2_int(kernel);
  endfunction

  function automatic int calc_ifm_size_next(input int ifm_size, input int kernel);
    return ifm_size / kernel;
  endfunction

  function automatic int counter_width(input int max_value);
    int w;
    w = log2_int(max_value + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pool_row_acc.sv
// ---------------------------------------------------------------------------
// pool_row_acc
// One accumulator per output column of the current output row. A single
// read/modify/write port indexed by oc folds the incoming pixel into the
// running window value (sum for average, signed max for max pooling).
//   clk       - clock
//   wr_en     - commit acc_next into entry oc
//   oc        - output column (window) index
//   first     - pixel is the top-left element of its window
//   mode      - POOL_AVG or POOL_MAX
//   in_data   - signed pixel
//   acc_next  - updated window value including in_data (combinational)
// The array holds no reset: every window starts by overwriting its entry.
// ---------------------------------------------------------------------------
module pool_row_acc
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 34,
  parameter int NUM_COLS   = 7,
  parameter int OC_W       = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [OC_W-1:0]       oc,
  input  logic                  first,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [ACC_WIDTH-1:0]  acc_next
);

  logic        [ACC_WIDTH-1:0] acc_mem [NUM_COLS];
  logic signed [ACC_WIDTH-1:0] pixel_ext;
  logic signed [ACC_WIDTH-1:0] acc_cur;

  assign pixel_ext = ACC_WIDTH'($signed(in_data));
  assign acc_cur   = acc_mem[oc];

  // The first element of a window replaces whatever the previous window left.
  always_comb begin
    acc_next = pixel_ext;
    if (!first) begin
      if (mode == POOL_MAX) begin
        acc_next = (acc_cur > pixel_ext) ? acc_cur : pixel_ext;
      end else begin
        acc_next = acc_cur + pixel_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      acc_mem[oc] <= acc_next;
    end
  end

endmodule

// File: rtl/pool_stream_unit.sv
// ---------------------------------------------------------------------------
// pool_stream_unit
// Streaming KxK (stride K) average/max pooling of IFM_DEPTH square maps fed
// one pixel per cycle in raster order.
//   clk, reset      - clock, asynchronous active-high reset
//   pool_clear      - synchronous clear of counters, mode and output register
//   pool_mode       - 0 average, 1 max; captured on the first pixel of a map
//   in_data/valid   - pixel stream in, in_ready back-pressures it
//   out_data/valid  - pooled result, held until out_ready
//   out_last_map    - result is the final output of the current map
//   out_last_frame  - result is the final output of the final map
// ---------------------------------------------------------------------------
module pool_stream_unit
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 14,
  parameter int IFM_DEPTH   = 3,
  parameter int KERNAL_SIZE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pool_clear,
  input  logic                  pool_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last_map,
  output logic                  out_last_frame
);

  localparam int IFM_SIZE_NEXT = calc_ifm_size_next(IFM_SIZE, KERNAL_SIZE);
  localparam int ACC_WIDTH     = calc_acc_width(DATA_WIDTH, KERNAL_SIZE);
  localparam int LOG2K         = log2_int(KERNAL_SIZE);
  localparam int SHIFT         = 2 * LOG2K;
  localparam int POS_W         = counter_width(IFM_SIZE);
  localparam int MAP_W         = counter_width(IFM_DEPTH);
  localparam int OC_W          = counter_width(IFM_SIZE_NEXT - 1);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(IFM_SIZE - 1);
  localparam logic [POS_W-1:0] CROP_END = POS_W'(IFM_SIZE_NEXT * KERNAL_SIZE);
  localparam logic [POS_W-1:0] WIN_LAST = POS_W'(IFM_SIZE_NEXT * KERNAL_SIZE - 1);
  localparam logic [POS_W-1:0] K_MASK   = POS_W'(KERNAL_SIZE - 1);
  localparam logic [MAP_W-1:0] MAP_LAST = MAP_W'(IFM_DEPTH - 1);

  if (KERNAL_SIZE < 2 || (KERNAL_SIZE & (KERNAL_SIZE - 1)) != 0) begin : g_bad_kernel
    $error("pool_stream_unit: KERNAL_SIZE must be a power of two >= 2");
  end
  if (IFM_SIZE < KERNAL_SIZE) begin : g_bad_size
    $error("pool_stream_unit: IFM_SIZE must be at least KERNAL_SIZE");
  end

  logic [POS_W-1:0]      row;
  logic [POS_W-1:0]      col;
  logic [MAP_W-1:0]      map;
  logic                  mode_q;
  logic                  accept;
  logic                  map_start;
  logic                  mode_eff;
  logic                  in_crop;
  logic                  win_first;
  logic                  win_last;
  logic                  acc_wr;
  logic                  win_done;
  logic                  map_done;
  logic [OC_W-1:0]       oc;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [DATA_WIDTH-1:0] pooled;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign map_start = (row == '0) && (col == '0);

  // The mode captured at a map's first pixel also governs that pixel itself.
  assign mode_eff  = map_start ? pool_mode : mode_q;

  // Right/bottom remainders that cannot fill a whole window are dropped.
  assign in_crop   = (row < CROP_END) && (col < CROP_END);
  assign win_first = ((row & K_MASK) == '0) && ((col & K_MASK) == '0);
  assign win_last  = ((row & K_MASK) == K_MASK) && ((col & K_MASK) == K_MASK);
  assign oc        = in_crop ? OC_W'(col >> LOG2K) : '0;

  assign acc_wr    = accept && in_crop && !pool_clear;
  assign win_done  = acc_wr && win_last;
  assign map_done  = win_done && (row == WIN_LAST) && (col == WIN_LAST);

  pool_row_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .NUM_COLS   (IFM_SIZE_NEXT),
    .OC_W       (OC_W)
  ) u_row_acc (
    .clk      (clk),
    .wr_en    (acc_wr),
    .oc       (oc),
    .first    (win_first),
    .mode     (mode_eff),
    .in_data  (in_data),
    .acc_next (acc_next)
  );

  // Average divides by K*K with an arithmetic shift, so results floor toward -inf.
  assign pooled = (mode_eff == POOL_MAX) ? acc_next[DATA_WIDTH-1:0]
                                         : DATA_WIDTH'($signed(acc_next) >>> SHIFT);

  // Raster position within the frame; the map index wraps so frames run back to back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row    <= '0;
      col    <= '0;
      map    <= '0;
      mode_q <= POOL_AVG;
    end else if (pool_clear) begin
      row    <= '0;
      col    <= '0;
      map    <= '0;
      mode_q <= POOL_AVG;
    end else if (accept) begin
      if (map_start) begin
        mode_q <= pool_mode;
      end
      if (col == POS_LAST) begin
        col <= '0;
        if (row == POS_LAST) begin
          row <= '0;
          map <= (map == MAP_LAST) ? '0 : map + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // A new result can only arrive while the register is empty or being drained,
  // so loading takes priority over clearing out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last_map   <= 1'b0;
      out_last_frame <= 1'b0;
    end else if (pool_clear) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last_map   <= 1'b0;
      out_last_frame <= 1'b0;
    end else if (win_done) begin
      out_valid      <= 1'b1;
      out_data       <= pooled;
      out_last_map   <= map_done;
      out_last_frame <= map_done && (map == MAP_LAST);
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_stream_unit.sv
// ---------------------------------------------------------------------------
// tb_pool_stream_unit
// Directed bench for pool_stream_unit. Three instances share clock and reset:
//   [0] 4x4, depth 1   [1] 5x5, depth 1   [2] 4x4, depth 3   (all K = 2)
// Accepted outputs are collected by a monitor and compared to expected values.
// ---------------------------------------------------------------------------
module tb_pool_stream_unit;

  localparam int DW    = 32;
  localparam int LIMIT = 50;

  logic          clk = 1'b0;
  logic          reset;
  logic          pool_clear     [3];
  logic          pool_mode      [3];
  logic [DW-1:0] in_data        [3];
  logic          in_valid       [3];
  logic          in_ready       [3];
  logic [DW-1:0] out_data       [3];
  logic          out_valid      [3];
  logic          out_ready      [3];
  logic          out_last_map   [3];
  logic          out_last_frame [3];

  typedef struct {
    int            sel;
    logic [DW-1:0] data;
    logic          last_map;
    logic          last_frame;
  } out_t;

  out_t obs_q[$];
  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic signed [DW-1:0] pix [25];

  always #5 clk = ~clk;

  pool_stream_unit #(.DATA_WIDTH(DW), .IFM_SIZE(4), .IFM_DEPTH(1), .KERNAL_SIZE(2)) u_dut_4x4 (
    .clk(clk), .reset(reset), .pool_clear(pool_clear[0]), .pool_mode(pool_mode[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last_map(out_last_map[0]), .out_last_frame(out_last_frame[0]));

  pool_stream_unit #(.DATA_WIDTH(DW), .IFM_SIZE(5), .IFM_DEPTH(1), .KERNAL_SIZE(2)) u_dut_5x5 (
    .clk(clk), .reset(reset), .pool_clear(pool_clear[1]), .pool_mode(pool_mode[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last_map(out_last_map[1]), .out_last_frame(out_last_frame[1]));

  pool_stream_unit #(.DATA_WIDTH(DW), .IFM_SIZE(4), .IFM_DEPTH(3), .KERNAL_SIZE(2)) u_dut_depth3 (
    .clk(clk), .reset(reset), .pool_clear(pool_clear[2]), .pool_mode(pool_mode[2]),
    .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_last_map(out_last_map[2]), .out_last_frame(out_last_frame[2]));

  // Inputs only change just after posedge, so a transfer seen here completes
  // at the following posedge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
        obs_q.push_back('{sel: i, data: out_data[i], last_map: out_last_map[i],
                          last_frame: out_last_frame[i]});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int sel, input logic signed [DW-1:0] value);
    int waited;
    waited = 0;
    in_data[sel]  = value;
    in_valid[sel] = 1'b1;
    @(negedge clk);
    while (in_ready[sel] !== 1'b1 && waited < LIMIT) begin
      waited++;
      @(negedge clk);
    end
    check_output("in_ready_wait", (waited < LIMIT), 1);
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
  endtask

  task automatic stream_range(input int sel, input int first_idx, input int last_idx);
    for (int i = first_idx; i <= last_idx; i++) apply_stimulus(sel, pix[i]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int sel, input logic signed [DW-1:0] value,
                          input logic last_map, input logic last_frame);
    exp_q.push_back('{sel: sel, data: value, last_map: last_map, last_frame: last_frame});
  endtask

  // Reference window result for a K=2 pool over an n x n map held in pix[].
  function automatic logic signed [DW-1:0] window_ref(input int n, input int orow,
                                                     input int ocol, input bit max_mode);
    longint acc;
    longint v;
    acc = 0;
    for (int kr = 0; kr < 2; kr++) begin
      for (int kc = 0; kc < 2; kc++) begin
        v = pix[(2 * orow + kr) * n + 2 * ocol + kc];
        if (kr == 0 && kc == 0) acc = v;
        else if (max_mode) acc = (v > acc) ? v : acc;
        else acc = acc + v;
      end
    end
    if (!max_mode) acc = acc >>> 2;
    return acc[DW-1:0];
  endfunction

  task automatic expect_map(input int sel, input int n, input bit max_mode, input bit last_frame);
    int on;
    on = n / 2;
    for (int r = 0; r < on; r++) begin
      for (int c = 0; c < on; c++) begin
        push_exp(sel, window_ref(n, r, c, max_mode), (r == on - 1 && c == on - 1),
                 last_frame && (r == on - 1 && c == on - 1));
      end
    end
  endtask

  task automatic compare_queues(input string tag);
    check_output({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_output($sformatf("%s_sel%0d", tag, i), obs_q[i].sel, exp_q[i].sel);
      check_output($sformatf("%s_data%0d", tag, i), $signed(obs_q[i].data), $signed(exp_q[i].data));
      check_output($sformatf("%s_lastmap%0d", tag, i), obs_q[i].last_map, exp_q[i].last_map);
      check_output($sformatf("%s_lastframe%0d", tag, i), obs_q[i].last_frame, exp_q[i].last_frame);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      pool_clear[i] = 1'b0;
      pool_mode[i]  = 1'b0;
      in_data[i]    = '0;
      in_valid[i]   = 1'b0;
      out_ready[i]  = 1'b1;
    end
    reset = 1'b1;
    wait_cycles(2);

    // Reset state
    @(negedge clk);
    check_output("rst_out_valid", out_valid[0], 0);
    check_output("rst_out_data", out_data[0], 0);
    check_output("rst_last_map", out_last_map[0], 0);
    check_output("rst_last_frame", out_last_frame[0], 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("post_rst_in_ready", in_ready[0], 1);
    @(posedge clk);
    #1;

    // 4x4 average, pixels 0..15
    $display("[TB] 4x4 average ramp");
    for (int i = 0; i < 16; i++) pix[i] = i;
    stream_range(0, 0, 15);
    wait_cycles(3);
    push_exp(0, 2, 0, 0);
    push_exp(0, 4, 0, 0);
    push_exp(0, 10, 0, 0);
    push_exp(0, 12, 1, 1);
    compare_queues("avg_ramp");

    // Partial junk, then a clear that collides with a handshake, then max mode
    $display("[TB] clear mid-map then 4x4 max ramp");
    apply_stimulus(0, 100);
    apply_stimulus(0, 200);
    apply_stimulus(0, 300);
    pool_clear[0] = 1'b1;
    apply_stimulus(0, 999);
    pool_clear[0] = 1'b0;
    pool_mode[0]  = 1'b1;
    stream_range(0, 0, 15);
    pool_mode[0]  = 1'b0;
    wait_cycles(3);
    push_exp(0, 5, 0, 0);
    push_exp(0, 7, 0, 0);
    push_exp(0, 13, 0, 0);
    push_exp(0, 15, 1, 1);
    compare_queues("max_ramp");

    // Negative average rounds toward -inf
    $display("[TB] 4x4 negative average");
    for (int i = 0; i < 16; i++) pix[i] = -1;
    pix[1] = -2;
    pix[4] = -3;
    pix[5] = -4;
    stream_range(0, 0, 15);
    wait_cycles(3);
    push_exp(0, -3, 0, 0);
    push_exp(0, -1, 0, 0);
    push_exp(0, -1, 0, 0);
    push_exp(0, -1, 1, 1);
    compare_queues("avg_negative");

    // Backpressure while the first window completes
    $display("[TB] 4x4 backpressure");
    for (int i = 0; i < 16; i++) pix[i] = i;
    out_ready[0] = 1'b0;
    stream_range(0, 0, 5);
    in_data[0]  = pix[6];
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("stall_in_ready", in_ready[0], 0);
      check_output("stall_out_valid", out_valid[0], 1);
      check_output("stall_out_data", $signed(out_data[0]), 2);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    stream_range(0, 6, 15);
    wait_cycles(3);
    expect_map(0, 4, 1'b0, 1'b1);
    compare_queues("backpressure");

    // 5x5 average: last row and column are discarded
    $display("[TB] 5x5 average with truncation");
    for (int i = 0; i < 25; i++) pix[i] = i;
    stream_range(1, 0, 24);
    wait_cycles(3);
    push_exp(1, 3, 0, 0);
    push_exp(1, 5, 0, 0);
    push_exp(1, 13, 0, 0);
    push_exp(1, 15, 1, 1);
    compare_queues("avg_5x5");

    // Depth 3: map 0 random, reset in the middle of map 1
    $display("[TB] depth 3 with reset mid map 1");
    for (int i = 0; i < 16; i++) pix[i] = $urandom();
    stream_range(2, 0, 15);
    wait_cycles(3);
    expect_map(2, 4, 1'b0, 1'b0);
    compare_queues("depth3_map0");
    for (int i = 0; i < 16; i++) pix[i] = $urandom();
    stream_range(2, 0, 4);
    out_ready[2] = 1'b0;
    apply_stimulus(2, pix[5]);
    @(negedge clk);
    check_output("map1_held_valid", out_valid[2], 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_output("midrst_out_valid", out_valid[2], 0);
    check_output("midrst_out_data", out_data[2], 0);
    check_output("midrst_last_map", out_last_map[2], 0);
    check_output("midrst_last_frame", out_last_frame[2], 0);
    @(negedge clk);
    reset        = 1'b0;
    out_ready[2] = 1'b1;
    @(posedge clk);
    #1;
    check_output("restart_in_ready", in_ready[2], 1);

    // Restart stream is map 0 again; mode captured on its first pixel only
    for (int i = 0; i < 16; i++) pix[i] = $urandom();
    pool_mode[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) pool_mode[2] = 1'b0;
      apply_stimulus(2, pix[i]);
    end
    wait_cycles(3);
    expect_map(2, 4, 1'b1, 1'b0);
    compare_queues("restart_map0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
